serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, operand set present on a, b and ci.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, the unsigned/two's-complement addends.
REQ-007 The block SHALL have port ci, input, 1, the carry-in.
REQ-008 The block SHALL have port out_valid, output, 1, result present on sum, co and ovf.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port sum, output, WIDTH, the result of a+b+ci modulo 2^WIDTH.
REQ-011 The block SHALL have port co, output, 1, the carry out of the MSB.
REQ-012 The block SHALL have port ovf, output, 1, signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE the block SHALL drive in_ready=1 and out_valid=0; in RUN and DONE it SHALL drive in_ready=0.
REQ-015 In IDLE, when in_valid=1 at a clock edge, the block SHALL capture a, b and ci into shift registers A, B and carry register C, clear bit counter cnt to 0, and go to RUN.
REQ-016 In IDLE with in_valid=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-017 At each RUN clock edge the block SHALL compute a one-bit full add of A[0], B[0] and C (s = A[0]^B[0]^C; c = A[0]&B[0] | (A[0]^B[0])&C).
REQ-018 At that same edge, A and B SHALL shift right by one, s SHALL shift into sum[WIDTH-1] while sum shifts right by one, C SHALL load c, and cnt SHALL increment.
REQ-019 At the RUN edge where cnt==WIDTH-2, the block SHALL record the incoming C as the carry into the MSB for the ovf computation.
REQ-020 At the RUN edge where cnt==WIDTH-1, the block SHALL load co=c and ovf=(MSB carry-in XOR c) and go to DONE; RUN therefore lasts exactly WIDTH cycles.
REQ-021 out_valid SHALL rise exactly WIDTH+1 clock edges after the accepting edge, inclusive of that edge.
REQ-022 In DONE the block SHALL drive out_valid=1, and sum, co and ovf SHALL remain stable until the handshake completes.
REQ-023 In DONE, an edge with out_ready=1 SHALL complete the handshake and return the FSM to IDLE; with out_ready=0 it SHALL stay in DONE indefinitely.
REQ-024 On leaving DONE, sum, co and ovf SHALL hold their values until the next result loads; these values are valid only while out_valid=1.
REQ-025 in_valid during RUN or DONE SHALL be ignored; no operand capture and no state change.
REQ-026 Back-to-back transfers SHALL NOT overlap: a new accept occurs no earlier than the edge after the DONE→IDLE edge, giving a minimum period of WIDTH+2 cycles.
REQ-027 Sum bits visible during RUN are partial and SHALL NOT be qualified by out_valid.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force state=IDLE and set A, B, C, cnt, sum, co and ovf to 0.
REQ-029 During reset the outputs SHALL be in_ready=1, out_valid=0, sum=0, co=0 and ovf=0.
REQ-030 When rst asserts mid-RUN or in DONE, the block SHALL abort the operation, lose the result, and produce no out_valid pulse.
REQ-031 After rst deasserts, the first edge SHALL behave as IDLE, accepting operands if in_valid=1.

Verification (WIDTH=8)
REQ-032 The bench SHALL apply a=0x5A, b=0x3C, ci=0 and check sum=0x96, co=0, ovf=1, with out_valid rising 9 edges after accept.
REQ-033 The bench SHALL apply a=0xFF, b=0x01, ci=0 and check sum=0x00, co=1, ovf=0; then a=0xFF, b=0xFF, ci=1 and check sum=0xFF, co=1, ovf=0.
REQ-034 The bench SHALL apply a=0x7F, b=0x00, ci=1 and check sum=0x80, co=0, ovf=1.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check out_valid and sum stable throughout; on out_ready=1 it SHALL check in_ready=1 the next cycle.
REQ-036 The bench SHALL toggle in_valid with different a and b during RUN and check that the result still reflects only the first operand set.
REQ-037 The bench SHALL pulse rst at cnt=3 and check in_ready=1, out_valid=0 and sum=0 immediately; a following accept of 0x01+0x01 SHALL yield sum=0x02.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, WIDTH cycles per
// operand set, with valid/ready handshakes on both the operand and result side.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             cmsb_q, cmsb_d;
  logic             fa_s, fa_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)        state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST)   state_d = DONE;
      DONE:    if (bus.out_ready)       state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.sum       = sum_q;
    bus.co        = co_q;
    bus.ovf       = ovf_q;
  end

  // Datapath next-state: capture in IDLE, one full-add and shift per RUN cycle
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    co_d   = co_q;
    ovf_d  = ovf_q;
    cmsb_d = cmsb_q;
    fa_s   = a_q[0] ^ b_q[0] ^ c_q;
    fa_c   = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.a;
          b_d   = bus.b;
          c_d   = bus.ci;
          cnt_d = '0;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        c_d   = fa_c;
        cnt_d = cnt_q + 1'b1;
        // carry produced by bit WIDTH-2 is the carry into the MSB
        if (cnt_q == CNT_PEN) cmsb_d = fa_c;
        if (cnt_q == CNT_LAST) begin
          co_d  = fa_c;
          ovf_d = cmsb_q ^ fa_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      cmsb_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      co_q   <= co_d;
      ovf_q  <= ovf_d;
      cmsb_q <= cmsb_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  res_t sb[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer add, signed overflow from operand/result signs
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    res_t r;
    logic [W:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    r.sum = full[W-1:0];
    r.co  = full[W];
    r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  // Drive one operand set; returns just after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    chk("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.a = a;
    bus.b = b;
    bus.ci = ci;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, ci));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("in_ready_in_run", bus.in_ready, 1'b0);
  endtask

  // Wait for the result (n0 = edges already elapsed incl. accept), compare,
  // hold out_ready low for 'hold' cycles, then complete the handshake.
  task automatic get_result(input int n0, input int hold);
    int n;
    res_t e;
    logic [W-1:0] snap;
    n = n0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 9);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!bus.out_valid) return;
    chk("sum", bus.sum, e.sum);
    chk("co", bus.co, e.co);
    chk("ovf", bus.ovf, e.ovf);
    snap = bus.sum;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = $urandom_range(0, 255);
      bus.b = $urandom_range(0, 255);
      @(posedge clk);
      #1;
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_sum", bus.sum, snap);
      chk("hold_co", bus.co, e.co);
      chk("hold_ovf", bus.ovf, e.ovf);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_hs", bus.in_ready, 1'b1);
    chk("out_valid_after_hs", bus.out_valid, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ci = 1'b0;

    // Reset values
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 8'h00);
    chk("rst_co", bus.co, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    send(8'h5A, 8'h3C, 1'b0); get_result(1, 0);
    send(8'hFF, 8'h01, 1'b0); get_result(1, 0);
    send(8'hFF, 8'hFF, 1'b1); get_result(1, 0);
    send(8'h7F, 8'h00, 1'b1); get_result(1, 5);

    // Operands toggling during RUN must be ignored
    send(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = 8'hF0 ^ 8'(i);
      bus.b = 8'h0F + 8'(i);
      bus.ci = ~bus.ci;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    get_result(5, 2);

    // Random traffic
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      get_result(1, int'($urandom_range(0, 2)));
    end

    // Abort mid-RUN at cnt=3
    send(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_sum", bus.sum, 8'h00);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) chk("abort_no_out_valid", bus.out_valid, 1'b0);
    end
    chk("abort_idle_ready", bus.in_ready, 1'b1);
    send(8'h01, 8'h01, 1'b0); get_result(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
